seq_mult_nxn: RTL and testbench
===============================

// Module: seq_mult_nxn
// PURPOSE
//   Parametrised iterative shift-add multiplier; sequential successor to the 8x8 combinational multiplier.
//   Computes a full 2*WIDTH-bit product of two WIDTH-bit operands, unsigned or two's-complement (per-op mode).
//   One multiplier bit is consumed per clock. Valid/ready handshake on input and output.
//   Sits between an operand source and a result sink that may stall.
// PARAMETERS
//   WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//   clk        in   1          single clock; all state changes on rising edge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          operands a/b/is_signed are valid
//   in_ready   out  1          block can accept operands (IDLE only)
//   a          in   WIDTH      multiplicand
//   b          in   WIDTH      multiplier
//   is_signed  in   1          1 = both operands two's-complement, 0 = both unsigned
//   out_valid  out  1          prod holds a completed result
//   out_ready  in   1          sink accepts prod
//   prod       out  2*WIDTH    product
// BEHAVIOUR
//   Reset (rst=1 at an edge, any state): state=IDLE, in_ready=1, out_valid=0, prod=0, counter=0, accumulator=0.
//     Reset mid-CALC or mid-DONE discards the operation; no result is ever presented for it.
//   FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_ready=1. Accept edge = in_valid&&in_ready: latch operands, cnt<=0, acc<=0, state<=CALC.
//     Signed mode: latch magnitudes |a|,|b| (WIDTH-bit unsigned) and neg = a[W-1]^b[W-1].
//     Unsigned mode: latch a,b as-is, neg=0. is_signed is sampled only on the accept edge.
//   CALC: in_ready=0, out_valid=0. Each edge: if mult LSB, acc += mcand << cnt (2*WIDTH-bit add,
//     cannot overflow); mult >>= 1; cnt++. On edge with cnt==WIDTH-1: prod <= neg ? -acc_final : acc_final
//     (2*WIDTH-bit two's complement), state<=DONE.
//   Latency: out_valid rises exactly WIDTH clocks after the accept edge.
//   DONE: out_valid=1, prod stable. Edge with out_ready=1: state<=IDLE, out_valid<=0 (prod keeps value).
//     out_ready=0: hold indefinitely; in_valid ignored (in_ready=0).
//   Throughput: one op per WIDTH+2 clocks under continuous in_valid/out_ready.
//   in_valid while in_ready=0 has no effect; operands need not be held after the accept edge.
//   Boundaries: signed -2^(W-1) has magnitude 2^(W-1), representable in WIDTH unsigned bits, so
//     (-2^(W-1))*(-2^(W-1)) = +2^(2W-2) is exact. Zero operand with neg=1 yields prod=0 (never -0 issue).
//     All-ones unsigned yields (2^W-1)^2, no truncation.
// TESTING (WIDTH=8)
//   1 Unsigned: a=0xD2,b=0x62,is_signed=0 -> prod=0x5064, out_valid exactly 8 clks after accept.
//   2 Unsigned: a=0xED,b=0xAA -> 0x9D62; a=0xFF,b=0xFF -> 0xFE01; a=0x00,b=0xFF -> 0x0000.
//   3 Signed: a=0xD2(-46),b=0x62(98) -> 0xEE64; a=0x80,b=0x80 -> 0x4000; a=0x80,b=0x01 -> 0xFF80.
//   4 Backpressure: out_ready=0 for 20 clks after out_valid -> prod stable, in_ready=0, new in_valid ignored;
//     out_ready=1 -> IDLE next clk, in_ready=1.
//   5 Reset mid-op: assert rst at CALC cycle 4 -> next clk in_ready=1, out_valid=0, prod=0; no stale result.
//   6 Back-to-back: two ops with in_valid/out_ready held 1 -> accepts spaced 10 clks, both products correct.

Source files
------------

// File: rtl/seq_mult_nxn.sv
// Iterative shift-add multiplier: one multiplier bit per clock, full 2*WIDTH-bit product,
// unsigned or two's-complement per operation, valid/ready on both sides.
module seq_mult_nxn #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mult_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic                 neg_reg;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_next;

  // In signed mode the operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag    = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag    = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    addend   = mult_reg[0] ? ({{WIDTH{1'b0}}, mcand_reg} << cnt_reg) : '0;
    acc_next = acc_reg + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      prod      <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mult_reg  <= '0;
      neg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg <= a_mag;
            mult_reg  <= b_mag;
            neg_reg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_reg   <= '0;
            acc_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg  <= acc_next;
          mult_reg <= mult_reg >> 1;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            // Negating a zero magnitude gives zero, so no negative-zero case exists.
            prod      <= neg_reg ? (~acc_next + 1'b1) : acc_next;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Scoreboard bench for seq_mult_nxn: expected products queued at accept, compared at output handshake.
module tb_seq_mult_nxn;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   prod;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [2*W-1:0] exp_q[$];
  int  accept_edge = 0;
  logic prev_out_valid = 1'b0;

  seq_mult_nxn #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint sx, sy, p;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  // Inputs change #1 after posedge, so values seen at negedge are what the next edge samples.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_out_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, is_signed));
        accept_edge = cycle + 1;
        $display("accept a=0x%02h b=0x%02h signed=%0b at edge %0d", a, b, is_signed, accept_edge);
      end
      if (out_valid && !prev_out_valid)
        check("latency", 64'(cycle - accept_edge), 64'(W));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(prod), 64'hDEAD);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          $display("result prod=0x%04h expected=0x%04h", prod, e);
          check("prod", 64'(prod), 64'(e));
        end
      end
      prev_out_valid <= out_valid;
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int edge_no);
    logic took;
    int n;
    took = 1'b0;
    n = 0;
    edge_no = -1;
    in_valid = 1'b1; a = x; b = y; is_signed = s;
    while (!took && n < 100) begin
      took = in_ready;
      go();
      n++;
    end
    if (took) edge_no = cycle;
    else check("accept_timeout", 64'(took), 64'(1));
    in_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      go();
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'(1));
  endtask

  typedef struct { logic [W-1:0] x; logic [W-1:0] y; logic s; } op_t;
  op_t vec[$];

  initial begin
    int e0, e1;
    logic [2*W-1:0] held;

    rst = 1'b1;
    go(); go();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_prod", 64'(prod), 64'(0));
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed unsigned/signed cases including boundaries.
    vec.push_back('{8'hD2, 8'h62, 1'b0});
    vec.push_back('{8'hED, 8'hAA, 1'b0});
    vec.push_back('{8'hFF, 8'hFF, 1'b0});
    vec.push_back('{8'h00, 8'hFF, 1'b0});
    vec.push_back('{8'hD2, 8'h62, 1'b1});
    vec.push_back('{8'h80, 8'h80, 1'b1});
    vec.push_back('{8'h80, 8'h01, 1'b1});
    vec.push_back('{8'h00, 8'h80, 1'b1});
    vec.push_back('{8'hFF, 8'h7F, 1'b1});
    for (int i = 0; i < 8; i++)
      vec.push_back('{W'($urandom), W'($urandom), 1'($urandom)});
    foreach (vec[i]) begin
      do_op(vec[i].x, vec[i].y, vec[i].s, e0);
      drain();
    end
    check("fixed_0xD2x0x62_u", 64'(model(8'hD2, 8'h62, 1'b0)), 64'h5064);

    // Backpressure: hold the result while new operands are offered.
    out_ready = 1'b0;
    do_op(8'h37, 8'hC9, 1'b1, e0);
    for (int n = 0; n < 50 && !out_valid; n++) go();
    check("bp_out_valid", 64'(out_valid), 64'(1));
    held = prod;
    in_valid = 1'b1; a = 8'h11; b = 8'h22; is_signed = 1'b0;
    for (int n = 0; n < 20; n++) begin
      go();
      if (prod !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        check("bp_prod_stable", 64'(prod), 64'(held));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid_hold", 64'(out_valid), 64'(1));
      end
    end
    check("bp_prod_final", 64'(prod), 64'(held));
    in_valid = 1'b0;
    out_ready = 1'b1;
    go();
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    check("bp_release_out_valid", 64'(out_valid), 64'(0));
    drain();

    // Reset during CALC discards the operation.
    do_op(8'h5A, 8'hA5, 1'b0, e0);
    go(); go(); go();
    rst = 1'b1;
    go();
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_prod", 64'(prod), 64'(0));
    for (int n = 0; n < 15; n++) begin
      go();
      if (out_valid !== 1'b0) check("midrst_stale", 64'(out_valid), 64'(0));
    end
    check("midrst_quiet", 64'(out_valid), 64'(0));

    // Back-to-back with in_valid and out_ready held high.
    do_op(8'h9C, 8'h3B, 1'b1, e0);
    do_op(8'hC3, 8'hE7, 1'b0, e1);
    check("b2b_spacing", 64'(e1 - e0), 64'(W + 2));
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
